reorder_commit_unit: RTL and testbench
======================================

// Module: reorder_commit_unit
// PURPOSE
//  In-order retirement buffer (ROB) that drives the rename commit interface.
//  - Accepts up to 4 renamed instructions per cycle from the rename stage.
//  - Tracks out-of-order completion reported by 2 writeback ports.
//  - Retires at most 1 instruction per cycle, driving Commit/Commit_Phy/Commit_Rdst.
//  - Raises Branch_flush when a mispredicted branch retires.
// PARAMETERS
//  DEPTH   16  entries; power of 2, >=8
//  TAG_W    4  log2(DEPTH)
//  PHY_W    6  physical register index width
//  ARCH_W   5  architectural register index width
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  Disp_Valid    in   4       per-lane instruction valid (lane0 = oldest)
//  Disp_RegW     in   4       per-lane writes a destination register
//  Disp_Branch   in   4       per-lane instruction is a branch
//  Disp_Rdst     in   4*5     per-lane architectural destination
//  Disp_Phydst   in   4*6     per-lane allocated physical destination
//  Disp_Ready    out  1       ROB can accept a full 4-lane group this cycle
//  Disp_Tag      out  4*4     per-lane ROB tag assigned (valid when accepted)
//  WB_Valid      in   2       writeback port valid
//  WB_Tag        in   2*4     ROB tag completed
//  WB_Mispred    in   2       completed branch was mispredicted
//  Commit        out  1       head retires and has RegW=1
//  Commit_Phy    out  6       physical destination of the retiring head
//  Commit_Rdst   out  5       architectural destination of the retiring head
//  Branch_flush  out  1       one-cycle pulse: mispredicted branch retiring
//  Rob_Empty     out  1       count == 0
// BEHAVIOUR
//  - Entry fields: busy, done, mispred, regw, branch, rdst, phy. head/tail are TAG_W bits; count is TAG_W+1 bits.
//  - Reset: head=tail=count=0; all busy/done/mispred cleared. Commit=0, Branch_flush=0, Rob_Empty=1, Disp_Ready=1.
//  - Dispatch:
//    - Disp_Ready = (DEPTH - count) >= 4, computed from registered count only; no credit for a same-cycle retire.
//    - Accept = Disp_Ready & |Disp_Valid & !Branch_flush.
//    - Valid lanes compact into consecutive entries from tail in lane order.
//    - Disp_Tag[k] = tail + popcount(Disp_Valid[k-1:0]), mod DEPTH.
//    - Accepted entries: busy=1, done=0, mispred=0. tail += n and count += n, where n = popcount(Disp_Valid).
//    - All-zero Disp_Valid is a no-op.
//  - Writeback:
//    - On each WB port: if WB_Valid and entry[WB_Tag].busy, set done=1 and mispred |= WB_Mispred. Writeback to a non-busy entry is ignored.
//    - Both ports hitting the same tag: flags are OR-ed.
//    - A writeback takes effect at the clock edge; the entry can retire the following cycle at the earliest (latency 1).
//  - Retire (combinational decode of registered head entry):
//    - ret = count != 0 & entry[head].done.
//    - Commit = ret & regw. Commit_Phy/Commit_Rdst = head fields and are valid whenever Commit=1; Rdst=0 is still reported.
//    - On ret: clear busy, head++, count--.
//  - Flush:
//    - Branch_flush = ret & branch & mispred.
//    - The branch itself retires in the flush cycle, with Commit per its regw.
//    - At that edge, every entry's busy/done/mispred is cleared, head=tail=0, count=0, and any same-cycle dispatch is dropped.
//  - Simultaneous dispatch + retire: count += n - 1.
//  - Wrap-around: head/tail roll over modulo DEPTH naturally.
//  - rst mid-operation overrides dispatch, writeback, retire and flush.
//  - No path from Disp_* to Commit* or to Branch_flush.
// CONFIGURATION
//  - ROB_PERF_CNT_EN defined:
//    - Adds outputs Perf_Retired[31:0] and Perf_Flush[15:0].
//    - Perf_Retired increments on every ret; Perf_Flush increments on every Branch_flush.
//    - Both wrap and are cleared by rst.
//  - ROB_PERF_CNT_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Reset, then idle -> Rob_Empty=1, Disp_Ready=1, Commit=0, Branch_flush=0.
//  2. Dispatch 4 lanes (RegW=1, Rdst 1..4, Phy 8..11). WB tags 3,2,1,0 on successive cycles
//     -> no Commit until tag0 done; then Commit on 4 consecutive cycles with Phy 8,9,10,11 in order.
//  3. Disp_Valid=4'b1010 -> Disp_Tag lane1=0, lane3=1; count=2.
//  4. Fill to count=13 -> Disp_Ready=0, and dispatch is ignored. Retire 1 -> count=12 -> Disp_Ready=1.
//  5. Branch at tag0 (RegW=0) with WB_Mispred=1, younger entries tags 1..5 done
//     -> single Branch_flush pulse with Commit=0; next cycle count=0, Rob_Empty=1, and no further Commit.
//  6. Run 40 dispatch/retire groups so head and tail wrap twice -> commit order matches dispatch order.
//     With ROB_PERF_CNT_EN, Perf_Retired equals the retired-instruction total.

Source files
------------

// File: rtl/reorder_commit_unit.sv
// reorder_commit_unit: in-order retirement buffer feeding the rename commit port.
// Accepts up to 4 renamed instructions per cycle and tracks out-of-order
// completion from 2 writeback ports. It retires at most one instruction per
// cycle and flushes the whole buffer when a mispredicted branch retires.
// Optional build macro ROB_PERF_CNT_EN adds retire/flush performance counters
// (Perf_Retired, Perf_Flush).
module reorder_commit_unit #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PHY_W  = 6,
  parameter int ARCH_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            Disp_Valid,
  input  logic [3:0]            Disp_RegW,
  input  logic [3:0]            Disp_Branch,
  input  logic [4*ARCH_W-1:0]   Disp_Rdst,
  input  logic [4*PHY_W-1:0]    Disp_Phydst,
  output logic                  Disp_Ready,
  output logic [4*TAG_W-1:0]    Disp_Tag,
  input  logic [1:0]            WB_Valid,
  input  logic [2*TAG_W-1:0]    WB_Tag,
  input  logic [1:0]            WB_Mispred,
  output logic                  Commit,
  output logic [PHY_W-1:0]      Commit_Phy,
  output logic [ARCH_W-1:0]     Commit_Rdst,
  output logic                  Branch_flush,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]           Perf_Retired,
  output logic [15:0]           Perf_Flush,
`endif
  output logic                  Rob_Empty
);

  // Control state: pointers, occupancy and per-entry status flags.
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  mispred;

  // Payload captured at dispatch; never needs reset because busy gates it.
  logic [DEPTH-1:0]  regw;
  logic [DEPTH-1:0]  branch;
  logic [ARCH_W-1:0] rdst_mem [DEPTH];
  logic [PHY_W-1:0]  phy_mem  [DEPTH];

  // Combinational decode.
  logic [TAG_W-1:0]  lane_tag [4];
  logic [TAG_W-1:0]  lane_ofs;
  logic [2:0]        disp_n;
  logic              accept;
  logic              ret;
  logic [TAG_W-1:0]  wb_tag0;
  logic [TAG_W-1:0]  wb_tag1;
  logic [DEPTH-1:0]  wb_done;
  logic [DEPTH-1:0]  wb_mis;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  done_nxt;
  logic [DEPTH-1:0]  mispred_nxt;
  logic [TAG_W:0]    count_nxt;
  logic [TAG_W-1:0]  tail_nxt;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Head decode: everything here comes from registered state only, so no
  // dispatch input can reach the commit or flush outputs.
  assign ret          = (count != '0) && done[head];
  assign Commit       = ret && regw[head];
  assign Commit_Phy   = phy_mem[head];
  assign Commit_Rdst  = rdst_mem[head];
  assign Branch_flush = ret && branch[head] && mispred[head];
  assign Rob_Empty    = (count == '0);

  // A full 4-lane group must fit; a retire in the same cycle earns no credit.
  assign Disp_Ready = (count <= (TAG_W+1)'(DEPTH - 4));
  assign disp_n     = popcnt4(Disp_Valid);
  assign accept     = Disp_Ready && (|Disp_Valid) && !Branch_flush;

  assign wb_tag0 = WB_Tag[TAG_W-1:0];
  assign wb_tag1 = WB_Tag[2*TAG_W-1:TAG_W];

  // Compact valid lanes onto consecutive slots starting at tail.
  always_comb begin
    lane_ofs = '0;
    Disp_Tag = '0;
    for (int k = 0; k < 4; k++) begin
      lane_tag[k] = tail + lane_ofs;
      Disp_Tag[k*TAG_W +: TAG_W] = lane_tag[k];
      lane_ofs = lane_ofs + TAG_W'(Disp_Valid[k]);
    end
  end

  // Writeback decode; both ports on one tag merge their mispredict flags.
  always_comb begin
    wb_done = '0;
    wb_mis  = '0;
    if (WB_Valid[0] && busy[wb_tag0]) begin
      wb_done[wb_tag0] = 1'b1;
      wb_mis[wb_tag0]  = WB_Mispred[0];
    end
    if (WB_Valid[1] && busy[wb_tag1]) begin
      wb_done[wb_tag1] = 1'b1;
      wb_mis[wb_tag1]  = wb_mis[wb_tag1] | WB_Mispred[1];
    end
  end

  // Next-state flags: merge writebacks, free the retiring head, claim new slots.
  always_comb begin
    busy_nxt    = busy;
    done_nxt    = done | wb_done;
    mispred_nxt = mispred | wb_mis;
    if (ret) begin
      busy_nxt[head]    = 1'b0;
      done_nxt[head]    = 1'b0;
      mispred_nxt[head] = 1'b0;
    end
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (Disp_Valid[k]) begin
          busy_nxt[lane_tag[k]]    = 1'b1;
          done_nxt[lane_tag[k]]    = 1'b0;
          mispred_nxt[lane_tag[k]] = 1'b0;
        end
      end
    end
  end

  assign tail_nxt  = tail + (accept ? TAG_W'(disp_n) : '0);
  assign count_nxt = count + (accept ? (TAG_W+1)'(disp_n) : '0) - (TAG_W+1)'(ret);

  // Control registers; a retiring mispredicted branch empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || Branch_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
    end else begin
      head    <= head + TAG_W'(ret);
      tail    <= tail_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      mispred <= mispred_nxt;
    end
  end

  // Payload write for accepted lanes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (accept && Disp_Valid[k]) begin
        regw[lane_tag[k]]     <= Disp_RegW[k];
        branch[lane_tag[k]]   <= Disp_Branch[k];
        rdst_mem[lane_tag[k]] <= Disp_Rdst[k*ARCH_W +: ARCH_W];
        phy_mem[lane_tag[k]]  <= Disp_Phydst[k*PHY_W +: PHY_W];
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Free-running retire and flush counters; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      Perf_Retired <= '0;
      Perf_Flush   <= '0;
    end else begin
      if (ret)          Perf_Retired <= Perf_Retired + 32'd1;
      if (Branch_flush) Perf_Flush   <= Perf_Flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_commit_unit.sv
// Testbench for reorder_commit_unit: directed scenarios plus a randomized run
// against a queue-based model of the retirement buffer.
module tb_reorder_commit_unit;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PHY_W  = 6;
  localparam int ARCH_W = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          Disp_Valid, Disp_RegW, Disp_Branch;
  logic [4*ARCH_W-1:0] Disp_Rdst;
  logic [4*PHY_W-1:0]  Disp_Phydst;
  logic                Disp_Ready;
  logic [4*TAG_W-1:0]  Disp_Tag;
  logic [1:0]          WB_Valid;
  logic [2*TAG_W-1:0]  WB_Tag;
  logic [1:0]          WB_Mispred;
  logic                Commit;
  logic [PHY_W-1:0]    Commit_Phy;
  logic [ARCH_W-1:0]   Commit_Rdst;
  logic                Branch_flush;
  logic                Rob_Empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]         Perf_Retired;
  logic [15:0]         Perf_Flush;
`endif

  always #5 clk = ~clk;

  reorder_commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PHY_W(PHY_W), .ARCH_W(ARCH_W)) dut (
    .clk(clk), .rst(rst),
    .Disp_Valid(Disp_Valid), .Disp_RegW(Disp_RegW), .Disp_Branch(Disp_Branch),
    .Disp_Rdst(Disp_Rdst), .Disp_Phydst(Disp_Phydst),
    .Disp_Ready(Disp_Ready), .Disp_Tag(Disp_Tag),
    .WB_Valid(WB_Valid), .WB_Tag(WB_Tag), .WB_Mispred(WB_Mispred),
    .Commit(Commit), .Commit_Phy(Commit_Phy), .Commit_Rdst(Commit_Rdst),
    .Branch_flush(Branch_flush),
`ifdef ROB_PERF_CNT_EN
    .Perf_Retired(Perf_Retired), .Perf_Flush(Perf_Flush),
`endif
    .Rob_Empty(Rob_Empty)
  );

  // Reference model: the buffer is simply an ordered list of in-flight instructions.
  typedef struct {
    bit       regw;
    bit       branch;
    bit       done;
    bit       mis;
    bit [4:0] rdst;
    bit [5:0] phy;
    int       tag;
  } ent_t;

  ent_t q[$];
  int   next_tag;
  int   retired_total;
  int   flush_total;
  int   n_tests;
  int   n_fail;

  function automatic void model_reset();
    q.delete();
    next_tag      = 0;
    retired_total = 0;
    flush_total   = 0;
  endfunction

  function automatic bit m_ready();
    return (DEPTH - q.size()) >= 4;
  endfunction

  function automatic bit m_ret();
    return (q.size() != 0) && q[0].done;
  endfunction

  function automatic bit m_commit();
    return m_ret() && q[0].regw;
  endfunction

  function automatic bit m_flush();
    return m_ret() && q[0].branch && q[0].mis;
  endfunction

  function automatic int m_tag(int k);
    int c;
    c = next_tag;
    for (int j = 0; j < k; j++) if (Disp_Valid[j]) c++;
    return c % DEPTH;
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  function automatic void model_edge();
    bit ret, fl, acc;
    ret = m_ret();
    fl  = m_flush();
    acc = m_ready() && (Disp_Valid != 4'h0) && !fl;
    for (int p = 0; p < 2; p++) begin
      if (WB_Valid[p]) begin
        int t;
        t = int'(WB_Tag[p*TAG_W +: TAG_W]);
        foreach (q[i]) begin
          if (q[i].tag == t) begin
            q[i].done = 1'b1;
            q[i].mis  = q[i].mis | WB_Mispred[p];
          end
        end
      end
    end
    if (ret) begin
      void'(q.pop_front());
      retired_total++;
    end
    if (fl) begin
      q.delete();
      next_tag = 0;
      flush_total++;
    end else if (acc) begin
      for (int k = 0; k < 4; k++) begin
        if (Disp_Valid[k]) begin
          ent_t e;
          e.regw   = Disp_RegW[k];
          e.branch = Disp_Branch[k];
          e.done   = 1'b0;
          e.mis    = 1'b0;
          e.rdst   = Disp_Rdst[k*ARCH_W +: ARCH_W];
          e.phy    = Disp_Phydst[k*PHY_W +: PHY_W];
          e.tag    = next_tag;
          q.push_back(e);
          next_tag = (next_tag + 1) % DEPTH;
        end
      end
    end
  endfunction

  task automatic idle();
    Disp_Valid  = 4'h0;
    Disp_RegW   = 4'h0;
    Disp_Branch = 4'h0;
    Disp_Rdst   = '0;
    Disp_Phydst = '0;
    WB_Valid    = 2'b00;
    WB_Tag      = '0;
    WB_Mispred  = 2'b00;
  endtask

  task automatic set_disp(input logic [3:0] v, input logic [3:0] rw, input logic [3:0] br,
                          input logic [4*ARCH_W-1:0] rd, input logic [4*PHY_W-1:0] ph);
    Disp_Valid  = v;
    Disp_RegW   = rw;
    Disp_Branch = br;
    Disp_Rdst   = rd;
    Disp_Phydst = ph;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [3:0] t1, input logic [3:0] t0,
                        input logic [1:0] mis);
    WB_Valid   = v;
    WB_Tag     = {t1, t0};
    WB_Mispred = mis;
  endtask

  // Commit the driven inputs to the model, then cross the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (Rob_Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", Rob_Empty); end
    n_tests++; if (Disp_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", Disp_Ready); end
    n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", Commit); end
    n_tests++; if (Branch_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", Branch_flush); end
    tick();
    @(negedge clk);
    n_tests++; if (Rob_Empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %b want 1", Rob_Empty); end
    tick();
  endtask

  task automatic test_inorder_commit();
    do_reset();
    set_disp(4'hF, 4'hF, 4'h0, {5'd4, 5'd3, 5'd2, 5'd1}, {6'd11, 6'd10, 6'd9, 6'd8});
    @(negedge clk);
    n_tests++; if (Disp_Tag !== 16'h3210) begin n_fail++; $display("FAIL inorder_tags: got %h want 3210", Disp_Tag); end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_wb(2'b01, 4'd0, 4'(3 - i), 2'b00);
      @(negedge clk);
      n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL inorder_early_commit[%0d]: got %b want 0", i, Commit); end
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (Commit !== 1'b1) begin n_fail++; $display("FAIL inorder_commit[%0d]: got %b want 1", i, Commit); end
      n_tests++; if (Commit_Phy !== 6'(8 + i)) begin n_fail++; $display("FAIL inorder_phy[%0d]: got %0d want %0d", i, Commit_Phy, 8 + i); end
      n_tests++; if (Commit_Rdst !== 5'(1 + i)) begin n_fail++; $display("FAIL inorder_rdst[%0d]: got %0d want %0d", i, Commit_Rdst, 1 + i); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL inorder_drained_commit: got %b want 0", Commit); end
    n_tests++; if (Rob_Empty !== 1'b1) begin n_fail++; $display("FAIL inorder_drained_empty: got %b want 1", Rob_Empty); end
    tick();
  endtask

  task automatic test_sparse_lanes();
    do_reset();
    set_disp(4'b1010, 4'b1010, 4'h0, {5'd7, 5'd0, 5'd6, 5'd0}, {6'd33, 6'd0, 6'd32, 6'd0});
    @(negedge clk);
    n_tests++; if (Disp_Tag[7:4] !== 4'd0) begin n_fail++; $display("FAIL sparse_lane1_tag: got %0d want 0", Disp_Tag[7:4]); end
    n_tests++; if (Disp_Tag[15:12] !== 4'd1) begin n_fail++; $display("FAIL sparse_lane3_tag: got %0d want 1", Disp_Tag[15:12]); end
    tick();
    set_disp(4'hF, 4'h0, 4'h0, '0, '0);
    @(negedge clk);
    n_tests++; if (Rob_Empty !== 1'b0) begin n_fail++; $display("FAIL sparse_not_empty: got %b want 0", Rob_Empty); end
    n_tests++; if (Disp_Tag !== 16'h5432) begin n_fail++; $display("FAIL sparse_next_tags: got %h want 5432", Disp_Tag); end
    tick();
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      set_disp(4'hF, 4'hF, 4'h0, 20'(g * 12345), 24'(g * 777));
      tick();
    end
    set_disp(4'b0001, 4'b0001, 4'h0, {15'd0, 5'd21}, {18'd0, 6'd44});
    tick();
    set_disp(4'hF, 4'hF, 4'h0, '0, '0);
    @(negedge clk);
    n_tests++; if (Disp_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready13: got %b want 0", Disp_Ready); end
    tick();
    idle();
    set_wb(2'b01, 4'd0, 4'd0, 2'b00);
    @(negedge clk);
    n_tests++; if (Disp_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_wb: got %b want 0", Disp_Ready); end
    tick();
    idle();
    set_disp(4'hF, 4'hF, 4'h0, '0, '0);
    @(negedge clk);
    n_tests++; if (Commit !== 1'b1) begin n_fail++; $display("FAIL full_retire: got %b want 1", Commit); end
    n_tests++; if (Disp_Ready !== 1'b0) begin n_fail++; $display("FAIL full_no_credit: got %b want 0", Disp_Ready); end
    tick();
    @(negedge clk);
    n_tests++; if (Disp_Ready !== 1'b1) begin n_fail++; $display("FAIL full_ready12: got %b want 1", Disp_Ready); end
    n_tests++; if (Disp_Tag[3:0] !== 4'd13) begin n_fail++; $display("FAIL full_tail_held: got %0d want 13", Disp_Tag[3:0]); end
    tick();
    idle();
    @(negedge clk);
    n_tests++; if (Disp_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready16: got %b want 0", Disp_Ready); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_disp(4'hF, 4'b1110, 4'b0001, {5'd4, 5'd3, 5'd2, 5'd9}, {6'd23, 6'd22, 6'd21, 6'd20});
    tick();
    set_disp(4'b0011, 4'b0011, 4'h0, {10'd0, 5'd6, 5'd5}, {12'd0, 6'd25, 6'd24});
    tick();
    idle();
    set_wb(2'b11, 4'd2, 4'd1, 2'b00);
    @(negedge clk);
    n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL flush_wait_commit0: got %b want 0", Commit); end
    tick();
    set_wb(2'b11, 4'd4, 4'd3, 2'b00);
    @(negedge clk);
    n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL flush_wait_commit1: got %b want 0", Commit); end
    tick();
    set_wb(2'b11, 4'd0, 4'd5, 2'b10);
    @(negedge clk);
    n_tests++; if (Branch_flush !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b want 0", Branch_flush); end
    tick();
    idle();
    set_disp(4'hF, 4'hF, 4'h0, '0, '0);
    @(negedge clk);
    n_tests++; if (Branch_flush !== 1'b1) begin n_fail++; $display("FAIL flush_pulse: got %b want 1", Branch_flush); end
    n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL flush_branch_commit: got %b want 0", Commit); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (Branch_flush !== 1'b0) begin n_fail++; $display("FAIL flush_single[%0d]: got %b want 0", i, Branch_flush); end
      n_tests++; if (Commit !== 1'b0) begin n_fail++; $display("FAIL flush_no_commit[%0d]: got %b want 0", i, Commit); end
      n_tests++; if (Rob_Empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty[%0d]: got %b want 1", i, Rob_Empty); end
      tick();
    end
    set_disp(4'b0001, 4'b0001, 4'h0, '0, '0);
    @(negedge clk);
    n_tests++; if (Disp_Tag[3:0] !== 4'd0) begin n_fail++; $display("FAIL flush_tail_reset: got %0d want 0", Disp_Tag[3:0]); end
    tick();
    idle();
  endtask

  task automatic test_random_wrap();
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      bit allow_mis;
      bit e_ret, e_commit, e_flush;
      allow_mis   = (cyc >= 350);
      Disp_Valid  = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'h0;
      Disp_RegW   = 4'($urandom);
      Disp_Branch = allow_mis ? 4'($urandom) : 4'h0;
      Disp_Rdst   = 20'($urandom);
      Disp_Phydst = 24'($urandom);
      WB_Valid    = 2'b00;
      WB_Tag      = '0;
      WB_Mispred  = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
          int idx;
          idx = $urandom_range(0, q.size() - 1);
          WB_Valid[p] = 1'b1;
          WB_Tag[p*TAG_W +: TAG_W] = 4'(q[idx].tag);
          WB_Mispred[p] = allow_mis && ($urandom_range(0, 9) == 0);
        end else if ($urandom_range(0, 7) == 0) begin
          WB_Valid[p] = 1'b1;
          WB_Tag[p*TAG_W +: TAG_W] = 4'($urandom);
          WB_Mispred[p] = 1'($urandom);
        end
      end
      @(negedge clk);
      e_ret    = m_ret();
      e_commit = m_commit();
      e_flush  = m_flush();
      n_tests++; if (Disp_Ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, Disp_Ready, m_ready()); end
      n_tests++; if (Rob_Empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b want %b", cyc, Rob_Empty, q.size() == 0); end
      n_tests++; if (Commit !== e_commit) begin n_fail++; $display("FAIL rnd_commit@%0d: got %b want %b", cyc, Commit, e_commit); end
      n_tests++; if (Branch_flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush@%0d: got %b want %b", cyc, Branch_flush, e_flush); end
      if (e_ret && e_commit) begin
        n_tests++; if (Commit_Phy !== q[0].phy) begin n_fail++; $display("FAIL rnd_phy@%0d: got %0d want %0d", cyc, Commit_Phy, q[0].phy); end
        n_tests++; if (Commit_Rdst !== q[0].rdst) begin n_fail++; $display("FAIL rnd_rdst@%0d: got %0d want %0d", cyc, Commit_Rdst, q[0].rdst); end
      end
      for (int k = 0; k < 4; k++) begin
        if (Disp_Valid[k]) begin
          n_tests++; if (Disp_Tag[k*TAG_W +: TAG_W] !== 4'(m_tag(k))) begin n_fail++; $display("FAIL rnd_tag%0d@%0d: got %0d want %0d", k, cyc, Disp_Tag[k*TAG_W +: TAG_W], m_tag(k)); end
        end
      end
      tick();
    end
    idle();
`ifdef ROB_PERF_CNT_EN
    @(negedge clk);
    n_tests++; if (Perf_Retired !== 32'(retired_total)) begin n_fail++; $display("FAIL perf_retired: got %0d want %0d", Perf_Retired, retired_total); end
    n_tests++; if (Perf_Flush !== 16'(flush_total)) begin n_fail++; $display("FAIL perf_flush: got %0d want %0d", Perf_Flush, flush_total); end
    tick();
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_inorder_commit();
    test_sparse_lanes();
    test_full();
    test_flush();
    test_random_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
